// File: rtl/bincount_gray.sv
// Up/down binary counter with a registered Gray-code twin, wrap pulse and load.
// Optional GRAY_STEP_CHECK_EN adds a sticky checker for single-bit Gray steps.
module bincount_gray #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  output logic             tc,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] b_q, g_q;
  logic [WIDTH-1:0] b_nxt, g_nxt;
  logic             tc_q, tc_nxt;
  logic             step;

  always_comb begin
    b_nxt  = b_q;
    tc_nxt = 1'b0;
    step   = 1'b0;
    if (load) begin
      b_nxt = load_val;
    end else if (en) begin
      step = 1'b1;
      if (up) begin
        b_nxt  = b_q + WIDTH'(1);
        tc_nxt = (b_q == MAX);
      end else begin
        b_nxt  = b_q - WIDTH'(1);
        tc_nxt = (b_q == ZERO);
      end
    end
    g_nxt = b_nxt ^ (b_nxt >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q  <= '0;
      g_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      b_q  <= b_nxt;
      g_q  <= g_nxt;
      tc_q <= tc_nxt;
    end
  end

  assign b  = b_q;
  assign g  = g_q;
  assign tc = tc_q;

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] g_prev;
  logic [WIDTH-1:0] diff;
  logic [4:0]       n_ones;
  logic             chk_q;
  logic             bad;
  logic             err_q;

  // g_prev holds the code from before the last step; compare once it lands
  always_comb begin
    diff   = g_q ^ g_prev;
    n_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n_ones = n_ones + {4'b0, diff[i]};
    end
    bad = chk_q && (n_ones != 5'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_prev <= '0;
      chk_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      g_prev <= g_q;
      chk_q  <= step;
      if (bad) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/bincount_gray.md
BINCOUNT_GRAY -- requirements
Module: bincount_gray

Interface
REQ-001 SHALL provide parameter: WIDTH, default 4, counter and code width in bits (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: en  input  1  count enable; one step per cycle while high.
REQ-005 SHALL have port: up  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 SHALL have port: load  input  1  synchronous load strobe.
REQ-007 SHALL have port: load_val  input  WIDTH  binary value written on load.
REQ-008 SHALL have port: b  output  WIDTH  registered binary count.
REQ-009 SHALL have port: g  output  WIDTH  registered Gray code of b, MSB = b MSB, g[i] = b[i+1] XOR b[i] below.
REQ-010 SHALL have port: tc  output  1  registered one-cycle terminal-count pulse.
REQ-011 SHALL have port: err  output  1  sticky Gray-step error flag (see Configuration).

Function
REQ-012 SHALL register b and g together from the same next-state value so g == Gray(b) in every cycle (zero relative latency, no combinational path from b to g at the outputs).
REQ-013 SHALL apply priority per edge: load > en > hold.
REQ-014 SHALL on load set b <= load_val, g <= Gray(load_val), regardless of en and up.
REQ-015 SHALL on en=1, load=0 set b <= b+1 (up=1) or b-1 (up=0), modulo 2^WIDTH.
REQ-016 SHALL on en=0, load=0 hold b and g unchanged.
REQ-017 SHALL wrap up-count from 2^WIDTH-1 to 0 and down-count from 0 to 2^WIDTH-1 with no stall.
REQ-018 SHALL assert tc for exactly the one cycle following a wrap edge (b just became 0 counting up, or 2^WIDTH-1 counting down); tc low otherwise.
REQ-019 SHALL NOT assert tc for a load, even when load_val is 0 or 2^WIDTH-1.
REQ-020 SHALL allow direction change on any cycle; the step uses up sampled on the same edge.
REQ-021 SHALL guarantee every en-driven step changes exactly one bit of g, including across wrap.
REQ-022 SHALL treat en/up/load/load_val as synchronous to clk; no internal synchronization.

Reset
REQ-023 SHALL on rst_n=0 immediately (asynchronously) force b=0, g=0, tc=0, err=0.
REQ-024 SHALL hold all outputs at reset values while rst_n=0 regardless of other inputs.
REQ-025 SHALL resume on the first rising clk edge after rst_n deassertion; a load or en on that edge takes effect.
REQ-026 SHALL abort an in-progress count on mid-operation reset with no residual tc pulse afterwards.

Configuration
REQ-027 SHALL use macro GRAY_STEP_CHECK_EN to include/exclude the Gray-step checker.
REQ-028 SHALL, when GRAY_STEP_CHECK_EN defined, compare g before and after each en-driven step and set err=1 on the following cycle if the Hamming distance is not exactly 1.
REQ-029 SHALL exempt load cycles and hold cycles from the check.
REQ-030 SHALL keep err set until rst_n asserts once set.
REQ-031 SHALL, when GRAY_STEP_CHECK_EN undefined, tie err to 0 with no checker logic synthesized; all other behaviour identical.

Verification
REQ-032 SHALL cover: reset, then en=1 up=1 for 16 cycles (WIDTH=4) -> b 1..15,0; g 0001,0011,0010,...,1000,0000; tc high only the cycle after b=0.
REQ-033 SHALL cover: load=1 load_val=1010 with en=1 -> next b=1010, g=1111, tc=0; following up step -> b=1011, g=1110.
REQ-034 SHALL cover: load_val=0000 load, then en=1 up=0 -> b=1111, g=1000, tc pulse one cycle; load of 1111 alone -> tc stays 0.
REQ-035 SHALL cover: counting up at b=0111, toggle up=0 on one edge -> b 1000 then 0111; g changes one bit per step; err stays 0.
REQ-036 SHALL cover: rst_n pulled low asynchronously mid-cycle at b=1101 -> b,g,tc,err 0 before next clk edge; count restarts from 0.
REQ-037 SHALL cover (GRAY_STEP_CHECK_EN): force g register to a two-bit jump via bench fault injection on an en step -> err=1 next cycle, held until reset; without macro err=0 throughout.
